// File: rtl/cubrt_pkg.sv
// Constants and state encoding shared by the cube-root stage, the BCD
// converter and the seven-segment display driver.
package cubrt_pkg;

  localparam int ROOT_W     = 27;
  localparam int BCD_DIGITS = 9;
  localparam int ROOT_FRAC  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/cubrt_bcd_conv.sv
// Sequential binary-to-BCD converter for the cube-root result: shift-add-3,
// one bit per clock, with leading-zero blanking above the units digit.
module cubrt_bcd_conv
  import cubrt_pkg::*;
#(
  parameter int N    = ROOT_W,
  parameter int D    = BCD_DIGITS,
  parameter int FRAC = ROOT_FRAC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [N-1:0]   BIN,
  output logic [4*D-1:0] BCD,
  output logic [D-1:0]   SHOW,
  output logic           ok,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [D-1:0] SHOW_RST = {{(D-FRAC-1){1'b0}}, {(FRAC+1){1'b1}}};

  conv_state_e    state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [4*D-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [D-1:0]   show_q, show_d;
  logic           ok_q, ok_d;
  logic           busy_q, busy_d;

  logic [4*D-1:0] acc_adj;
  logic [4*D-1:0] acc_shift;
  logic [N-1:0]   sr_shift;
  logic [D-1:0]   show_next;
  logic           seen;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  assign acc_shift = {acc_adj[4*D-2:0], sr_q[N-1]};
  assign sr_shift  = {sr_q[N-2:0], 1'b0};

  // Blanking scans from the most significant digit down; once a nonzero
  // digit is seen every lower digit is shown, and the units/fraction always.
  always_comb begin
    seen      = 1'b0;
    show_next = '0;
    for (int i = D - 1; i >= 0; i--) begin
      seen         = seen | (acc_shift[4*i +: 4] != 4'd0);
      show_next[i] = seen | (i <= FRAC);
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    show_d  = show_q;
    ok_d    = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (st) begin
          sr_d    = BIN;
          acc_d   = '0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q == CW'(1)) begin
          bcd_d  = acc_shift;
          show_d = show_next;
          ok_d   = 1'b1;
        end
        // A start wins over both shifting and completion: the run restarts,
        // while a completing run has still published its result above.
        if (st) begin
          sr_d   = BIN;
          acc_d  = '0;
          cnt_d  = CW'(N);
          busy_d = 1'b1;
        end else if (cnt_q == CW'(1)) begin
          sr_d    = sr_shift;
          acc_d   = acc_shift;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          sr_d  = sr_shift;
          acc_d = acc_shift;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      show_q  <= SHOW_RST;
      ok_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      show_q  <= show_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
    end
  end

  assign BCD  = bcd_q;
  assign SHOW = show_q;
  assign ok   = ok_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cubrt_bcd_conv.sv
// Scoreboard bench for cubrt_bcd_conv: stimulus pushes expected results
// computed by decimal arithmetic; a monitor pops them when ok pulses.
module tb_cubrt_bcd_conv;

  localparam int N       = 27;
  localparam int D       = 9;
  localparam int LAT     = 27;
  localparam logic [8:0] SHOW_RST = 9'b000111111;

  typedef struct {
    logic [35:0] bcd;
    logic [8:0]  show;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        st;
  logic [N-1:0] BIN;
  logic [35:0] BCD;
  logic [8:0]  SHOW;
  logic        ok;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t pend[$];
  logic [35:0] exp_bcd  = '0;
  logic [8:0]  exp_show = SHOW_RST;
  logic        prev_ok  = 1'b0;

  cubrt_bcd_conv dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .BIN  (BIN),
    .BCD  (BCD),
    .SHOW (SHOW),
    .ok   (ok),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [35:0] model_bcd(input logic [26:0] v);
    longint unsigned x = v;
    logic [35:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [8:0] model_show(input logic [26:0] v);
    longint unsigned p = 1;
    logic [8:0] s = '0;
    for (int i = 0; i < D; i++) begin
      s[i] = (i <= 5) || (longint'(v) >= p);
      p = p * 10;
    end
    return s;
  endfunction

  // Drives st for one edge; an in-flight run not finishing on that edge is aborted.
  task automatic issue(input logic [26:0] b);
    exp_t e;
    @(negedge clk);
    st  = 1'b1;
    BIN = b;
    @(negedge clk);
    if (pend.size() > 0 && pend[$].due > cyc) void'(pend.pop_back());
    e.bcd  = model_bcd(b);
    e.show = model_show(b);
    e.due  = cyc + LAT;
    pend.push_back(e);
    st  = 1'b0;
    BIN = 27'($urandom);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    #1;
    if (!rst) begin
      if (pend.size() > 0 && pend[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_ok: result due at cycle %0d not seen by cycle %0d", pend[0].due, cyc);
        void'(pend.pop_front());
      end
      if (ok) begin
        check("ok_single_pulse", prev_ok, 1'b0);
        if (pend.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ok at cycle %0d: got ok=1, expected ok=0", cyc);
        end else begin
          e = pend.pop_front();
          check("ok_latency", cyc, e.due);
          check("bcd_result", BCD, e.bcd);
          check("show_result", SHOW, e.show);
          exp_bcd  = e.bcd;
          exp_show = e.show;
        end
      end else begin
        check("bcd_hold", BCD, exp_bcd);
        check("show_hold", SHOW, exp_show);
      end
      exp_busy = (pend.size() > 0) && (pend[$].due > cyc);
      check("busy", busy, exp_busy);
      prev_ok = ok;
    end else begin
      prev_ok = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    rst = 1'b1;
    st  = 1'b0;
    BIN = '0;
    #1;
    check("reset_bcd", BCD, 36'h0);
    check("reset_show", SHOW, SHOW_RST);
    check("reset_ok", ok, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(27'd0);
    repeat (30) @(negedge clk);
    issue(27'd134217727);
    repeat (30) @(negedge clk);
    issue(27'd125992);
    repeat (30) @(negedge clk);
    issue(27'd12345678);
    repeat (30) @(negedge clk);

    // Restart: second start sampled ten edges after the first.
    issue(27'd999);
    repeat (8) @(negedge clk);
    issue(27'd100000);
    repeat (30) @(negedge clk);

    // Reset thirteen cycles into a conversion.
    issue(27'd4321);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    pend.delete();
    exp_bcd  = '0;
    exp_show = SHOW_RST;
    #2;
    check("midrst_bcd", BCD, 36'h0);
    check("midrst_show", SHOW, SHOW_RST);
    check("midrst_ok", ok, 1'b0);
    check("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(27'd4321);
    repeat (30) @(negedge clk);

    // Back-to-back: second start on the completion edge of the first.
    issue(27'd7);
    repeat (25) @(negedge clk);
    issue(27'd88);
    repeat (30) @(negedge clk);

    // Random values with random spacing; short gaps abort, gap 25 chains.
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 32);
      if (n % 7 == 3) gap = 25;
      repeat (gap) @(negedge clk);
      issue(27'($urandom_range(0, 134217727)));
    end

    for (int t = 0; t < 200 && pend.size() > 0; t++) @(negedge clk);
    if (pend.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", pend.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
